// File: rtl/bdcc_tx.sv
// bdcc_tx: serial frame transmitter.
// A frame is one HO sync pulse followed by 16 data pulses, MSB first. Each
// data pulse is on IM1 for a '1' bit or on IM0 for a '0' bit, and every pulse
// is followed by a low gap. All outputs come straight from flops.
module bdcc_tx #(
  parameter int HO_LEN    = 8,  // sync pulse length, 7..255
  parameter int PULSE_LEN = 2,  // data pulse length, 1..255
  parameter int GAP_LEN   = 2   // low gap length, 1..255
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] iData,
  input  logic        iVal,
  output logic        oBusy,
  output logic        oDone,
  output logic        HO,
  output logic        IM1,
  output logic        IM0
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SYNC = 3'd1;
  localparam logic [2:0] SGAP = 3'd2;
  localparam logic [2:0] BIT  = 3'd3;
  localparam logic [2:0] BGAP = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  // Terminal counts: the counter runs 0..LEN-1 inside a state, so it never
  // needs to reach 255 and can never wrap.
  localparam logic [7:0] HO_TC    = 8'(HO_LEN - 1);
  localparam logic [7:0] PULSE_TC = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_TC   = 8'(GAP_LEN - 1);

  logic [2:0]  state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [3:0]  idx_reg, idx_next;
  logic [15:0] data_reg, data_next;

  logic ho_reg, ho_next;
  logic im1_reg, im1_next;
  logic im0_reg, im0_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;

  // Next-state, counter, bit index and word latch
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    case (state_reg)
      IDLE: begin
        // iVal is only looked at here, so the latched word is stable mid-frame
        if (iVal) begin
          data_next  = iData;
          idx_next   = 4'd15;
          cnt_next   = 8'd0;
          state_next = SYNC;
        end
      end
      SYNC: begin
        if (cnt_reg == HO_TC) begin
          cnt_next   = 8'd0;
          state_next = SGAP;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      SGAP: begin
        if (cnt_reg == GAP_TC) begin
          cnt_next   = 8'd0;
          state_next = BIT;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      BIT: begin
        if (cnt_reg == PULSE_TC) begin
          cnt_next   = 8'd0;
          state_next = BGAP;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      BGAP: begin
        if (cnt_reg == GAP_TC) begin
          cnt_next = 8'd0;
          if (idx_reg == 4'd0) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg - 4'd1;
            state_next = BIT;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  // Output decode from the upcoming state, so the output flops change on the
  // same edge as the state register and no input reaches an output directly
  always_comb begin
    ho_next   = (state_next == SYNC);
    im1_next  = (state_next == BIT) &&  data_next[idx_next];
    im0_next  = (state_next == BIT) && !data_next[idx_next];
    busy_next = (state_next == SYNC) || (state_next == SGAP) ||
                (state_next == BIT)  || (state_next == BGAP);
    done_next = (state_next == DONE);
  end

  // State and output registers with synchronous reset (also aborts a frame)
  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      idx_reg   <= 4'd0;
      data_reg  <= 16'd0;
      ho_reg    <= 1'b0;
      im1_reg   <= 1'b0;
      im0_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      ho_reg    <= ho_next;
      im1_reg   <= im1_next;
      im0_reg   <= im0_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign HO    = ho_reg;
  assign IM1   = im1_reg;
  assign IM0   = im0_reg;
  assign oBusy = busy_reg;
  assign oDone = done_reg;

endmodule

// File: tb/tb_bdcc_tx.sv
// tb_bdcc_tx: table-driven frame checks for bdcc_tx with a cycle-exact
// expected waveform, plus reset, back-to-back and receiver loopback sequences.
module tb_bdcc_tx;

  localparam int HL = 8;
  localparam int PL = 2;
  localparam int GL = 2;
  localparam int DONE_K = HL + GL + 16 * (PL + GL) + 1;  // 75
  localparam int PERIOD = DONE_K + 1;                    // 76 with iVal held

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] iData;
  logic        iVal;
  logic        oBusy, oDone, HO, IM1, IM0;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  bdcc_tx #(.HO_LEN(HL), .PULSE_LEN(PL), .GAP_LEN(GL)) dut (
    .clk  (clk),
    .RST  (RST),
    .iData(iData),
    .iVal (iVal),
    .oBusy(oBusy),
    .oDone(oDone),
    .HO   (HO),
    .IM1  (IM1),
    .IM0  (IM0)
  );

  always #5 clk = ~clk;

  // Simple receiver: >=7 HO-high cycles arm it, then 16 pulse rising edges
  // are shifted in MSB first; rx_test pulses once per complete frame.
  int          rx_run    = 0;
  logic        rx_active = 1'b0;
  int          rx_bits   = 0;
  logic [15:0] rx_sh     = 16'd0;
  logic        rx_p1     = 1'b0;
  logic        rx_p0     = 1'b0;
  logic        rx_test   = 1'b0;
  int          rx_frames = 0;
  logic [15:0] rx_word   = 16'd0;

  always @(negedge clk) begin
    rx_run  <= HO ? rx_run + 1 : 0;
    rx_test <= 1'b0;
    if (!HO && rx_run >= 7) begin
      rx_active <= 1'b1;
      rx_bits   <= 0;
      rx_sh     <= 16'd0;
    end else if (rx_active && ((IM1 && !rx_p1) || (IM0 && !rx_p0))) begin
      rx_sh   <= {rx_sh[14:0], IM1};
      rx_bits <= rx_bits + 1;
      if (rx_bits == 15) begin
        rx_active <= 1'b0;
        rx_test   <= 1'b1;
        rx_frames <= rx_frames + 1;
        rx_word   <= {rx_sh[14:0], IM1};
      end
    end
    rx_p1 <= IM1;
    rx_p0 <= IM0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected {HO,IM1,IM0,oBusy,oDone} in cycle k of a frame accepted in cycle 0
  function automatic logic [4:0] exp_at(input logic [15:0] d, input int k);
    int t, b, ph;
    if (k < 1) return 5'b00000;
    if (k <= HL) return 5'b10010;
    if (k <= HL + GL) return 5'b00010;
    t = k - HL - GL - 1;
    if (t < 16 * (PL + GL)) begin
      b  = t / (PL + GL);
      ph = t % (PL + GL);
      if (ph < PL) return d[15 - b] ? 5'b01010 : 5'b00110;
      return 5'b00010;
    end
    if (k == DONE_K) return 5'b00001;
    return 5'b00000;
  endfunction

  typedef struct {
    logic [15:0] data;
    int          inj_k;   // cycle in which a stray iVal/1234 is driven (0 = none)
    int          rst_k;   // cycle in which RST is driven (0 = none)
    int          ones;    // expected IM1 pulses
    int          zeros;   // expected IM0 pulses
    int          frames;  // frames the receiver should decode
  } vec_t;

  // Runs one frame from an idle DUT; called right after a sample point.
  task automatic run_frame(input vec_t v, input int idx);
    int ones, zeros, f0;
    logic p1, p0;
    logic [4:0] obs, exp;
    ones = 0; zeros = 0; p1 = 0; p0 = 0;
    f0 = rx_frames;
    iData = v.data;
    iVal  = 1'b1;
    for (int k = 1; k <= 85; k++) begin
      @(posedge clk); #1;
      obs = {HO, IM1, IM0, oBusy, oDone};
      exp = (v.rst_k > 0 && k > v.rst_k) ? 5'b00000 : exp_at(v.data, k);
      chk($sformatf("vec%0d cycle%0d lines", idx, k), {27'd0, obs}, {27'd0, exp});
      chk($sformatf("vec%0d cycle%0d onehot", idx, k),
          32'($countones({HO, IM1, IM0}) <= 1), 32'd1);
      if (IM1 && !p1) ones++;
      if (IM0 && !p0) zeros++;
      p1 = IM1; p0 = IM0;
      iVal  = (k == v.inj_k);
      iData = (k == v.inj_k) ? 16'h1234 : v.data;
      RST   = (k == v.rst_k);
    end
    iVal = 1'b0;
    RST  = 1'b0;
    chk($sformatf("vec%0d im1_pulses", idx), ones, v.ones);
    chk($sformatf("vec%0d im0_pulses", idx), zeros, v.zeros);
    chk($sformatf("vec%0d rx_frames", idx), rx_frames - f0, v.frames);
    if (v.frames > 0) chk($sformatf("vec%0d rx_word", idx), {16'd0, rx_word}, {16'd0, v.data});
    $display("vec%0d data=%04h ones=%0d zeros=%0d", idx, v.data, ones, zeros);
  endtask

  vec_t vecs[6];

  initial begin
    int f0;
    logic [4:0] exp;
    vecs[0] = '{16'hA5C3, 0,  0,  8,  8, 1};  // reference frame
    vecs[1] = '{16'h0000, 0,  0,  0, 16, 1};  // all zeros
    vecs[2] = '{16'hFFFF, 0,  0, 16,  0, 1};  // all ones
    vecs[3] = '{16'hA5C3, 20, 0,  8,  8, 1};  // stray iVal mid-frame
    vecs[4] = '{16'hA5C3, 0, 44,  5,  4, 0};  // reset during bit 7
    vecs[5] = '{16'h8001, 0,  0,  2, 14, 1};  // fresh frame after abort

    // Reset with iVal high: nothing may start
    RST = 1'b1; iVal = 1'b1; iData = 16'hA5C3;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk($sformatf("reset%0d outputs", i), {27'd0, HO, IM1, IM0, oBusy, oDone}, 32'd0);
      $display("reset cycle %0d outputs=%b", i, {HO, IM1, IM0, oBusy, oDone});
    end
    RST = 1'b0; iVal = 1'b0;
    @(posedge clk); #1;
    chk("post_reset idle", {27'd0, HO, IM1, IM0, oBusy, oDone}, 32'd0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

    // Back-to-back: iVal held for three frames, then dropped
    f0 = rx_frames;
    iData = 16'hA5C3;
    iVal  = 1'b1;
    for (int k = 1; k <= 240; k++) begin
      int f, loc;
      @(posedge clk); #1;
      f   = (k - 1) / PERIOD;
      loc = k - PERIOD * f;
      exp = (f < 3) ? exp_at(16'hA5C3, loc) : 5'b00000;
      chk($sformatf("b2b cycle%0d lines", k), {27'd0, HO, IM1, IM0, oBusy, oDone}, {27'd0, exp});
      if (k == 3 * PERIOD) iVal = 1'b0;
    end
    chk("b2b rx_frames", rx_frames - f0, 3);
    chk("b2b rx_word", {16'd0, rx_word}, {16'd0, 16'hA5C3});
    $display("b2b frames decoded=%0d word=%04h", rx_frames - f0, rx_word);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/bdcc_tx.md
BDCC_TX -- requirements
Module: bdcc_tx

Parameters
REQ-001 SHALL provide HO_LEN, default 8, HO sync-pulse length in clk cycles; legal range 7..255, because the receiver needs at least 7 consecutive HO-high cycles.
REQ-002 SHALL provide PULSE_LEN, default 2, IM1/IM0 data-pulse length in cycles; legal range 1..255.
REQ-003 SHALL provide GAP_LEN, default 2, low gap after HO and after each data pulse, in cycles; legal range 1..255.

Interface
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 RST  input  1  synchronous reset, active-high.
REQ-006 iData  input  16  word to transmit; sampled only on acceptance.
REQ-007 iVal  input  1  start request; qualifies iData.
REQ-008 oBusy  output  1  frame in progress.
REQ-009 oDone  output  1  one-cycle pulse at end of frame.
REQ-010 HO  output  1  frame sync line.
REQ-011 IM1  output  1  "one" bit pulse line.
REQ-012 IM0  output  1  "zero" bit pulse line.

Function
REQ-013 SHALL drive all outputs from registers, with no combinational path from any input to any output.
REQ-014 SHALL implement states IDLE, SYNC, SGAP, BIT, BGAP, DONE, using an 8-bit cycle counter and a 4-bit bit index.
REQ-015 SHALL, in IDLE with iVal=1, latch iData, set bit index to 15 and enter SYNC; iVal=0 keeps IDLE.
REQ-016 SHALL hold HO=1 for exactly HO_LEN cycles in SYNC, starting the cycle after acceptance.
REQ-017 SHALL hold all lines low for GAP_LEN cycles in SGAP, then enter BIT.
REQ-018 SHALL, in BIT, drive IM1=1 if the current latched bit is 1, else IM0=1, for exactly PULSE_LEN cycles, then enter BGAP.
REQ-019 SHALL hold lines low for GAP_LEN cycles in BGAP, then: if bit index is 0, enter DONE; otherwise decrement the index and enter BIT (transmission is MSB first).
REQ-020 SHALL assert oDone=1 for exactly one cycle in DONE, then return to IDLE.
REQ-021 SHALL assert oBusy=1 from the first SYNC cycle through the last BGAP cycle, and 0 in IDLE and DONE.
REQ-022 SHALL ignore iVal in every state except IDLE; the latched word SHALL NOT change mid-frame.
REQ-023 SHALL never assert more than one of HO, IM1, IM0 in the same cycle.
REQ-024 Frame timing: acceptance in cycle 0; HO high in cycles 1..HO_LEN; oDone in cycle HO_LEN+GAP_LEN+16*(PULSE_LEN+GAP_LEN)+1, which is 75 with default parameters.
REQ-025 SHALL handle iVal held continuously high as back-to-back frames: DONE, then acceptance in IDLE, then HO rises in the next cycle, giving a minimum of 2 idle cycles between the last gap and the next HO.
REQ-026 SHALL terminate counters on exact terminal-count compare; counters SHALL never wrap.

Reset
REQ-027 SHALL, while RST=1 at a clock edge, force HO=IM1=IM0=oBusy=oDone=0, state IDLE, counters 0 and latched data 0.
REQ-028 SHALL, when RST is asserted mid-frame, abort the frame and drive all outputs low from the next edge; no oDone is issued for the aborted frame.
REQ-029 SHALL ignore iVal while RST=1; the first acceptance is possible in the first cycle with RST=0.

Verification
REQ-030 Reset: RST=1 for 2 cycles with iVal=1 -> all outputs 0 and no frame starts during reset.
REQ-031 Single frame, default parameters: iData=16'hA5C3 with a 1-cycle iVal -> HO high in cycles 1..8; pulse lines in order 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 (IM1 for 1, IM0 for 0), each 2 cycles high and 2 low; oDone in cycle 75 only; oBusy high in cycles 1..74.
REQ-032 Extremes: 16'h0000 -> 16 IM0 pulses and IM1 never high; 16'hFFFF -> 16 IM1 pulses and IM0 never high; checker confirms one-hot/idle on HO, IM1 and IM0 every cycle.
REQ-033 Busy protection: iVal=1 with iData=16'h1234 in cycle 20 of a 16'hA5C3 frame -> frame unchanged, no second frame, a single oDone.
REQ-034 Reset mid-frame: RST=1 for 1 cycle during bit 7 -> lines and oBusy are 0 from the next cycle with no oDone; a fresh iVal with 16'h8001 then produces a complete correct frame.
REQ-035 Back-to-back and loopback: iVal held high for 3 frames -> 3 frames with exactly 2 low cycles between the last gap and the next HO; a receiver on HO/IM1/IM0 pulses its TEST output once per frame.
